// File: rtl/ccd_sync_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer/filter.
// Parameter limits are checked against these at elaboration.
package ccd_sync_pkg;

  localparam int WIDTH_MAX         = 256;
  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 10;
  localparam int FILTER_CYCLES_MAX = 1023;

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ccd_sync_filter_chan.sv
// One channel: synchronizer chain, stability filter and edge pulses.
// The first chain flop is the metastability-catching stage.
module ccd_sync_filter_chan
  import ccd_sync_pkg::*;
#(
  parameter int   SYNC_STAGES   = 3,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic async_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out,
  output logic edge_next_out
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  logic [SYNC_STAGES-2:0] tail_q;
  logic [SYNC_STAGES-2:0] tail_d;
  logic                   sync;
  logic                   level_q;
  logic                   level_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;

  // Pure shift of the chain; nothing sits between the flops.
  always_comb begin
    tail_d    = tail_q << 1;
    tail_d[0] = meta_q;
  end

  // Synchronizer flops, loaded with the reset level.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      meta_q <= RESET_VALUE;
      tail_q <= {(SYNC_STAGES-1){RESET_VALUE}};
    end else begin
      meta_q <= async_in;
      tail_q <= tail_d;
    end
  end

  assign sync = tail_q[SYNC_STAGES-2];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      // No filtering: follow the synchronized level every edge.
      always_comb level_d = sync;
    end else begin : g_filter
      localparam int CW = clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Accept a new level only after it has held long enough.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync != level_q) begin
          if (cnt_q == LAST) level_d = sync;
          else               cnt_d   = cnt_q + CW'(1);
        end
      end

      // Stability counter; cleared on reset or when levels agree.
      always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end
    end
  endgenerate

  // Edge detect on the accepted level, registered with it.
  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // Filtered level and edge pulse registers.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      level_q <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out     = level_q;
  assign rise_out      = rise_q;
  assign fall_out      = fall_q;
  assign edge_next_out = rise_d | fall_d;

endmodule

// File: rtl/ccd_sync_filter.sv
// Multi-channel level synchronizer with deglitch filter and edge pulses.
// Channels are independent; change_out flags any edge in a cycle.
module ccd_sync_filter
  import ccd_sync_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_STAGES   = 3,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] input_in,
  output logic [WIDTH-1:0] output_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             change_out
);

  logic [WIDTH-1:0] edge_next;
  logic             change_q;
  logic             change_d;

  generate
    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("ccd_sync_filter: WIDTH out of range");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN ||
        SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("ccd_sync_filter: SYNC_STAGES out of range");
    end
    if (FILTER_CYCLES < 0 ||
        FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_bad_filt
      $error("ccd_sync_filter: FILTER_CYCLES out of range");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      ccd_sync_filter_chan #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .RESET_VALUE   (RESET_VALUE[i])
      ) u_chan (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .async_in      (input_in[i]),
        .level_out     (output_out[i]),
        .rise_out      (rise_out[i]),
        .fall_out      (fall_out[i]),
        .edge_next_out (edge_next[i])
      );
    end
  endgenerate

  // Any channel edge next cycle raises change in step with the pulses.
  always_comb change_d = |edge_next;

  // Change flag register.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) change_q <= 1'b0;
    else          change_q <= change_d;
  end

  assign change_out = change_q;

endmodule

// File: tb/tb_ccd_sync_filter.sv
// Scoreboard bench for ccd_sync_filter: filtered, bypass and
// reset-value instances with directed steps, glitches and resets.
module tb_ccd_sync_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_a = 4'b0000;
  logic [3:0] in_b = 4'b0000;
  logic [3:0] in_r = 4'b1010;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] out_b, rise_b, fall_b;
  logic [3:0] out_r, rise_r, fall_r;
  logic       chg_a, chg_b, chg_r;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] out;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ccd_sync_filter #(
    .WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(4),
    .RESET_VALUE(4'b0000)
  ) dut_a (
    .clock_in(clk), .reset_in(rst), .input_in(in_a),
    .output_out(out_a), .rise_out(rise_a), .fall_out(fall_a),
    .change_out(chg_a)
  );

  ccd_sync_filter #(
    .WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0),
    .RESET_VALUE(4'b0000)
  ) dut_b (
    .clock_in(clk), .reset_in(rst), .input_in(in_b),
    .output_out(out_b), .rise_out(rise_b), .fall_out(fall_b),
    .change_out(chg_b)
  );

  ccd_sync_filter #(
    .WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(4),
    .RESET_VALUE(4'b1010)
  ) dut_r (
    .clock_in(clk), .reset_in(rst), .input_in(in_r),
    .output_out(out_r), .rise_out(rise_r), .fall_out(fall_r),
    .change_out(chg_r)
  );

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push_a(int c, logic [3:0] r, logic [3:0] f,
                        logic [3:0] o);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.out = o;
    qa.push_back(e);
  endtask

  task automatic push_b(int c, logic [3:0] r, logic [3:0] f,
                        logic [3:0] o);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.out = o;
    qb.push_back(e);
  endtask

  // Wait for the next edge and step just past it.
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for the filtered instance.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (chg_a || (|rise_a) || (|fall_a))) begin
      if (qa.size() == 0) begin
        check("a_spurious", {20'd0, chg_a, 3'd0, rise_a, fall_a}, 0);
      end else begin
        e = qa.pop_front();
        check("a_cycle", cyc, e.cyc);
        check("a_rise", {28'd0, rise_a}, {28'd0, e.rise});
        check("a_fall", {28'd0, fall_a}, {28'd0, e.fall});
        check("a_out", {28'd0, out_a}, {28'd0, e.out});
        check("a_change", {31'd0, chg_a}, 1);
      end
    end
  end

  // Monitor for the bypass instance.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (chg_b || (|rise_b) || (|fall_b))) begin
      if (qb.size() == 0) begin
        check("b_spurious", {20'd0, chg_b, 3'd0, rise_b, fall_b}, 0);
      end else begin
        e = qb.pop_front();
        check("b_cycle", cyc, e.cyc);
        check("b_rise", {28'd0, rise_b}, {28'd0, e.rise});
        check("b_fall", {28'd0, fall_b}, {28'd0, e.fall});
        check("b_out", {28'd0, out_b}, {28'd0, e.out});
        check("b_change", {31'd0, chg_b}, 1);
      end
    end
  end

  initial begin
    int n;

    // Reset state
    tick(3);
    check("rst_out_a", {28'd0, out_a}, 0);
    check("rst_out_r", {28'd0, out_r}, 32'h0000000a);
    check("rst_edges_a", {23'd0, chg_a, rise_a, fall_a}, 0);
    rst = 1'b0;

    // Reset level holds with no edge pulses after release
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_out_r", {28'd0, out_r}, 32'h0000000a);
      check("hold_edges_r", {23'd0, chg_r, rise_r, fall_r}, 0);
    end

    // Clean step on channel 0
    tick(1);
    in_a[0] = 1'b1;
    push_a(cyc + 7, 4'b0001, 4'b0000, 4'b0001);
    tick(12);

    // 3-cycle glitch on channel 1 is rejected
    in_a[1] = 1'b1;
    tick(3);
    in_a[1] = 1'b0;
    tick(12);
    check("glitch3_out", {28'd0, out_a}, 32'h1);

    // 4-cycle pulse on channel 1 passes, edges 4 apart
    in_a[1] = 1'b1;
    n = cyc;
    push_a(n + 7, 4'b0010, 4'b0000, 4'b0011);
    tick(4);
    in_a[1] = 1'b0;
    push_a(n + 11, 4'b0000, 4'b0010, 4'b0001);
    tick(14);

    // Channel 0 falls
    in_a[0] = 1'b0;
    push_a(cyc + 7, 4'b0000, 4'b0001, 4'b0000);
    tick(12);

    // Reset in the middle of a count on channel 2
    in_a[2] = 1'b1;
    tick(5);
    rst = 1'b1;
    #1;
    check("midrst_out", {28'd0, out_a}, 0);
    check("midrst_edges", {23'd0, chg_a, rise_a, fall_a}, 0);
    tick(2);
    rst = 1'b0;
    push_a(cyc + 7, 4'b0100, 4'b0000, 4'b0100);
    tick(6);
    check("midrst_early", {28'd0, out_a}, 0);
    tick(6);

    // Channel 2 back low
    in_a = 4'b0000;
    push_a(cyc + 7, 4'b0000, 4'b0100, 4'b0000);
    tick(12);

    // All channels rise together
    in_a = 4'b1111;
    push_a(cyc + 7, 4'b1111, 4'b0000, 4'b1111);
    tick(12);
    check("simul_out", {28'd0, out_a}, 32'hf);

    // Bypass: 1-cycle pulse on channel 0
    in_b[0] = 1'b1;
    n = cyc;
    push_b(n + 3, 4'b0001, 4'b0000, 4'b0001);
    tick(1);
    in_b[0] = 1'b0;
    push_b(n + 4, 4'b0000, 4'b0001, 4'b0000);
    tick(8);

    // Bypass: level step on channel 3
    in_b[3] = 1'b1;
    push_b(cyc + 3, 4'b1000, 4'b0000, 4'b1000);
    tick(8);
    check("byp_out", {28'd0, out_b}, 32'h8);

    // Every expected edge must have been seen
    check("a_pending", qa.size(), 0);
    check("b_pending", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
